io_bus_responder: RTL

Memory-mapped I/O responder on the core's data-memory bus, in parallel with `data_memory`. It claims the top 32 bytes of the 9-bit data address space and returns read data with the same one-cycle registered latency as `data_memory`, so the core's MEM/WB timing is unchanged. It owns `io_output_bus`, synchronises `io_input_bus` and captures its rising edges, and provides a free-running cycle timer. The top-level muxes `q` against `data_memory.q` using `hit_q`.

---
 rtl/io_bus_responder_pkg.sv | 36 +++
 rtl/io_bus_responder_input_synchronizer.sv | 32 +++
 rtl/io_bus_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/io_bus_responder_pkg.sv
// Shared I/O map for the memory-mapped responder: bus widths, window base,
// register byte offsets and the register-index encoding of address[4:2].
package io_bus_responder_pkg;

   localparam int         IO_WIDTH = 11;
   localparam logic [8:0] IO_BASE  = 9'h1E0;

   // Byte offsets inside the 32-byte window, shared with core top and software.
   localparam logic [4:0] IO_OUT     = 5'h00;
   localparam logic [4:0] IO_OUT_SET = 5'h04;
   localparam logic [4:0] IO_OUT_CLR = 5'h08;
   localparam logic [4:0] IO_IN      = 5'h0C;
   localparam logic [4:0] IO_EDGE    = 5'h10;
   localparam logic [4:0] IO_TIMER   = 5'h14;

   // Word index (address[4:2]) of each register.
   typedef enum logic [2:0] {
      REG_OUT     = 3'd0,
      REG_OUT_SET = 3'd1,
      REG_OUT_CLR = 3'd2,
      REG_IN      = 3'd3,
      REG_EDGE    = 3'd4,
      REG_TIMER   = 3'd5,
      REG_RSVD0   = 3'd6,
      REG_RSVD1   = 3'd7
   } io_reg_e;

   // Warm-up counter value at which edge capture becomes armed.
   localparam logic [1:0] WARM_DONE = 2'd2;

   // Window decode: only the upper four address bits select the window.
   function automatic logic io_hit(input logic [8:0] addr, input logic [8:0] base);
      return addr[8:5] == base[8:5];
   endfunction

endpackage

// File: rtl/io_bus_responder_input_synchronizer.sv
// Two-flop synchroniser per input bit plus rising-edge detect. The edge
// output is derived from registered s1/s2 and is forced low while arm is 0,
// so the caller can hold off capture until the chain holds real samples.
module input_synchronizer #(
   parameter int WIDTH = 11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             arm,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;

   // Synchroniser chain: s1 samples the pin, s2 is the stable copy.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
      end
   end

   assign sync_out = s2;
   assign rise     = s1 & ~s2 & {WIDTH{arm}};

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder sitting beside data_memory. Claims the top
// 32 bytes of the 9-bit data space and answers reads with one registered
// cycle of latency; hit_q tells the top which q to forward.
module io_bus_responder #(
   parameter int         IO_WIDTH = io_bus_responder_pkg::IO_WIDTH,
   parameter logic [8:0] BASE     = io_bus_responder_pkg::IO_BASE
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [8:0]          address,
   input  logic [31:0]         data,
   input  logic                wren,
   output logic [31:0]         q,
   output logic                hit_q,
   input  logic [IO_WIDTH-1:0] io_input_bus,
   output logic [IO_WIDTH-1:0] io_output_bus
);

   import io_bus_responder_pkg::*;

   logic                hit;
   logic                wr;
   io_reg_e             idx;
   logic [IO_WIDTH-1:0] wdata;
   logic [IO_WIDTH-1:0] out_r;
   logic [IO_WIDTH-1:0] edge_r;
   logic [IO_WIDTH-1:0] edge_clr;
   logic [IO_WIDTH-1:0] in_sync;
   logic [IO_WIDTH-1:0] rise;
   logic [31:0]         timer_r;
   logic [31:0]         rd_data;
   logic [1:0]          warm_r;
   logic                arm;
   logic                unused_addr_lsb;

   assign hit             = io_hit(address, BASE);
   assign wr              = wren & hit;
   assign idx             = io_reg_e'(address[4:2]);
   assign wdata           = data[IO_WIDTH-1:0];
   assign arm             = (warm_r == WARM_DONE);
   assign edge_clr        = (wr && idx == REG_EDGE) ? wdata : '0;
   assign unused_addr_lsb = ^address[1:0];
   assign io_output_bus   = out_r;

   input_synchronizer #(
      .WIDTH (IO_WIDTH)
   ) u_sync (
      .clock    (clock),
      .reset    (reset),
      .arm      (arm),
      .async_in (io_input_bus),
      .sync_out (in_sync),
      .rise     (rise)
   );

   // Warm-up counter: saturates at WARM_DONE, arming edge capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         warm_r <= '0;
      end else if (warm_r != WARM_DONE) begin
         warm_r <= warm_r + 2'd1;
      end
   end

   // Output register: plain write, set and clear strobes.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_r <= '0;
      end else if (wr) begin
         case (idx)
            REG_OUT:     out_r <= wdata;
            REG_OUT_SET: out_r <= out_r | wdata;
            REG_OUT_CLR: out_r <= out_r & ~wdata;
            default:     out_r <= out_r;
         endcase
      end
   end

   // Sticky edge flags: clear is applied first so a same-cycle edge survives.
   always_ff @(posedge clock) begin
      if (reset) begin
         edge_r <= '0;
      end else begin
         edge_r <= (edge_r & ~edge_clr) | rise;
      end
   end

   // Free-running timer; a store overrides the increment for that cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         timer_r <= '0;
      end else if (wr && idx == REG_TIMER) begin
         timer_r <= data;
      end else begin
         timer_r <= timer_r + 32'd1;
      end
   end

   // Read mux over pre-write register values.
   always_comb begin
      rd_data = '0;
      case (idx)
         REG_OUT, REG_OUT_SET, REG_OUT_CLR: rd_data = 32'(out_r);
         REG_IN:                            rd_data = 32'(in_sync);
         REG_EDGE:                          rd_data = 32'(edge_r);
         REG_TIMER:                         rd_data = timer_r;
         default:                           rd_data = '0;
      endcase
   end

   // Registered read response, zero outside the window.
   always_ff @(posedge clock) begin
      if (reset) begin
         q     <= '0;
         hit_q <= 1'b0;
      end else begin
         q     <= hit ? rd_data : 32'd0;
         hit_q <= hit;
      end
   end

endmodule
